// File: rtl/a5_1_pkg.sv
// a5_1_pkg: A5/1 register geometry, key slicing and decryptor state encoding
package a5_1_pkg;
  localparam int X_LEN = 19;
  localparam int Y_LEN = 22;
  localparam int Z_LEN = 23;
  localparam logic [X_LEN-1:0] X_TAPS = 19'h72000;
  localparam logic [Y_LEN-1:0] Y_TAPS = 22'h300000;
  localparam logic [Z_LEN-1:0] Z_TAPS = 23'h700080;
  localparam int X_CLK = 8;
  localparam int Y_CLK = 10;
  localparam int Z_CLK = 10;
  localparam int X_MSB = 63;
  localparam int X_LSB = 45;
  localparam int Y_MSB = 44;
  localparam int Y_LSB = 23;
  localparam int Z_MSB = 22;
  localparam int Z_LSB = 0;
  typedef enum logic [1:0] {IDLE, WARM, GEN, HAVE} state_e;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/a5_1_lfsr.sv
// a5_1_lfsr: one loadable A5/1 register shifting toward the MSB with XOR-tap feedback
module a5_1_lfsr #(
  parameter int LEN = 19,
  parameter logic [LEN-1:0] TAPS = '0,
  parameter int CLK_BIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [LEN-1:0] load_value,
  input  logic           step,
  output logic           msb,
  output logic           clk_bit
);
  logic [LEN-1:0] r_q, r_d;
  always_comb r_d = load ? load_value : step ? {r_q[LEN-2:0], ^(r_q & TAPS)} : r_q;
  always_ff @(posedge clk) r_q <= !rst_n ? '0 : r_d;
  assign msb = r_q[LEN-1];
  assign clk_bit = r_q[CLK_BIT];
endmodule

// File: rtl/a5_1_pixel_decryptor.sv
// a5_1_pixel_decryptor: A5/1 keystream generator XOR-decrypting a valid/ready pixel byte stream
module a5_1_pixel_decryptor
  import a5_1_pkg::*;
#(
  parameter int WARMUP_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [63:0] key,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        busy
);
  localparam int CW = $clog2(WARMUP_CYCLES + 2);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] ks_q, ks_d, m_data_q, m_data_d;
  logic m_valid_q, m_valid_d;
  logic stepping, maj, ks_bit, hs;
  logic x_msb, y_msb, z_msb, x_clk, y_clk, z_clk;
  assign stepping = !key_load && (state_q == WARM || state_q == GEN);
  assign maj = maj3(x_clk, y_clk, z_clk);
  assign ks_bit = x_msb ^ y_msb ^ z_msb;
  a5_1_lfsr #(.LEN(X_LEN), .TAPS(X_TAPS), .CLK_BIT(X_CLK)) u_x (
    .clk(clk), .rst_n(rst_n), .load(key_load), .load_value(key[X_MSB:X_LSB]),
    .step(stepping && x_clk == maj), .msb(x_msb), .clk_bit(x_clk));
  a5_1_lfsr #(.LEN(Y_LEN), .TAPS(Y_TAPS), .CLK_BIT(Y_CLK)) u_y (
    .clk(clk), .rst_n(rst_n), .load(key_load), .load_value(key[Y_MSB:Y_LSB]),
    .step(stepping && y_clk == maj), .msb(y_msb), .clk_bit(y_clk));
  a5_1_lfsr #(.LEN(Z_LEN), .TAPS(Z_TAPS), .CLK_BIT(Z_CLK)) u_z (
    .clk(clk), .rst_n(rst_n), .load(key_load), .load_value(key[Z_MSB:Z_LSB]),
    .step(stepping && z_clk == maj), .msb(z_msb), .clk_bit(z_clk));
  assign s_ready = state_q == HAVE && (!m_valid_q || m_ready) && !key_load;
  assign hs = s_valid && s_ready;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign busy = state_q == WARM || state_q == GEN;
  // The next keystream byte keeps generating while a plaintext byte waits on m_ready.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    ks_d = ks_q;
    m_data_d = m_data_q;
    m_valid_d = m_valid_q && !m_ready;
    if (key_load) begin
      state_d = WARMUP_CYCLES == 0 ? GEN : WARM;
      cnt_d = '0;
      bit_d = '0;
      ks_d = '0;
      m_valid_d = 1'b0;
    end else if (state_q == WARM) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_d == CW'(WARMUP_CYCLES) ? GEN : WARM;
    end else if (state_q == GEN) begin
      ks_d = {ks_q[6:0], ks_bit};
      bit_d = bit_q + 1'b1;
      state_d = bit_q == 3'd7 ? HAVE : GEN;
    end else if (hs) begin
      m_data_d = s_data ^ ks_q;
      m_valid_d = 1'b1;
      state_d = GEN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      ks_q <= '0;
      m_data_q <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      ks_q <= ks_d;
      m_data_q <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end
endmodule
